mux_nto1_rr: RTL and testbench

MUX_NTO1_RR -- requirements
Module: mux_nto1_rr

---
 rtl/mux_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/mux_nto1_rr.sv | 138 +++++++++++++
 tb/tb_mux_nto1_rr.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 packet multiplexer: FSM encoding and
// channel-index width helper.
package mux_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } mux_state_e;

  // Channel index width: clog2(n), never narrower than one bit.
  function automatic int calc_cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: first requesting channel starting at ptr, wrapping
// modulo NCH.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NCH = 4,
  localparam int CW = calc_cw(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [CW-1:0]  gnt_idx,
  output logic           gnt_any
);

  int idx;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NCH;
      if (req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[CW-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-to-1 packet multiplexer with select and round-robin modes; a channel
// keeps the grant from its first beat until its last beat.
//
// state   | meaning
// --------+------------------------------------------------
// ST_IDLE | no packet open; arbitrate by mode (sel or rr)
// ST_LOCK | packet open on channel lch; only lch is granted
module mux_nto1_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  localparam int CW   = calc_cw(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [CW-1:0]        sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH-1:0]       in_last,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [CW-1:0]        out_ch,
  input  logic                 out_ready
);

  mux_state_e state, state_n;
  logic [CW-1:0] lch, lch_n;
  logic [CW-1:0] ptr, ptr_n;

  logic [CW-1:0]    rr_idx;
  logic             rr_any;
  logic [CW-1:0]    gnt;
  logic             gnt_any;
  logic             space;
  logic             accept;
  logic             g_valid;
  logic             g_last;
  logic [WIDTH-1:0] g_data;

  rr_arbiter #(.NCH(NCH)) u_rr (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  always_comb begin
    gnt     = lch;
    gnt_any = 1'b0;
    case (state)
      ST_LOCK: begin
        gnt     = lch;
        gnt_any = 1'b1;
      end
      default: begin
        if (mode) begin
          gnt     = rr_idx;
          gnt_any = rr_any;
        end else begin
          for (int i = 0; i < NCH; i++) begin
            if (sel == CW'(i) && in_valid[i]) begin
              gnt     = sel;
              gnt_any = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    g_valid  = 1'b0;
    g_last   = 1'b0;
    g_data   = '0;
    in_ready = '0;
    space    = !out_valid || out_ready;
    for (int i = 0; i < NCH; i++) begin
      if (gnt == CW'(i)) begin
        g_valid     = in_valid[i];
        g_last      = in_last[i];
        g_data      = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = !rst && gnt_any && space;
      end
    end
    accept = !rst && gnt_any && space && g_valid;
  end

  always_comb begin
    state_n = state;
    lch_n   = lch;
    ptr_n   = ptr;
    if (accept) begin
      if (g_last) begin
        state_n = ST_IDLE;
        if (mode) begin
          ptr_n = (gnt == CW'(NCH - 1)) ? '0 : gnt + 1'b1;
        end
      end else begin
        state_n = ST_LOCK;
        lch_n   = gnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      lch   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      lch   <= lch_n;
      ptr   <= ptr_n;
    end
  end

  // Output register holds its contents while the downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
      out_last  <= g_last;
      out_ch    <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Directed self-checking bench for mux_nto1_rr (WIDTH=8, NCH=4).
module tb_mux_nto1_rr;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int CW    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 mode;
  logic [CW-1:0]        sel;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_last;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_last;
  logic [CW-1:0]        out_ch;
  logic                 out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux_nto1_rr #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [7:0] val);
    in_data[ch*WIDTH +: WIDTH] = val;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input int ch, input logic l);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_ch"},    32'(out_ch),    32'(ch));
    chk({tag, "_last"},  32'(out_last),  32'(l));
  endtask

  logic [1:0] rr_seq [5];

  initial begin
    rst = 1'b1; mode = 1'b1; sel = '0; in_data = '0;
    in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
    step();
    step();
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data",  32'(out_data),  32'h0);
    chk("rst_ch",    32'(out_ch),    32'h0);
    chk("rst_last",  32'(out_last),  32'h0);

    // Select mode, channel 2 single-beat packet.
    rst = 1'b0; mode = 1'b0; sel = 2'd2;
    in_valid = 4'b0100; in_last = 4'b0100; set_data(2, 8'hC0);
    #1;
    chk("sel2_ready", 32'(in_ready), 32'b0100);
    step();
    in_valid = '0;
    chk_out("sel2", 8'hC0, 2, 1'b1);
    step();
    chk("sel2_drain", 32'(out_valid), 32'h0);

    // Select mode pointing at an idle channel: no grant.
    sel = 2'd3; in_valid = 4'b0001; in_last = 4'b0001;
    #1;
    chk("sel3_ready", 32'(in_ready), 32'h0);
    step();
    chk("sel3_nov1", 32'(out_valid), 32'h0);
    step();
    chk("sel3_nov2", 32'(out_valid), 32'h0);

    // Round-robin over four always-valid single-beat channels.
    mode = 1'b1; in_valid = 4'hF; in_last = 4'hF;
    for (int i = 0; i < NCH; i++) set_data(i, 8'(8'h10 + i));
    rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_ch",   32'(out_ch),   32'(rr_seq[i]));
      chk("rr_data", 32'(out_data), 32'(8'h10 + rr_seq[i]));
    end
    in_valid = '0;
    step();
    chk("rr_drain", 32'(out_valid), 32'h0);

    // ptr is now 1: ch1 3-beat packet while ch0/ch2 also request.
    in_valid = 4'b0111; in_last = 4'b0000;
    set_data(0, 8'h01); set_data(1, 8'hA0); set_data(2, 8'h22);
    step();
    chk_out("pkt_a", 8'hA0, 1, 1'b0);
    set_data(1, 8'hB0);
    step();
    chk_out("pkt_b", 8'hB0, 1, 1'b0);
    set_data(1, 8'hC0); in_last = 4'b0010;
    step();
    chk_out("pkt_c", 8'hC0, 1, 1'b1);
    in_valid = 4'b0101; in_last = 4'b0101;
    step();
    chk_out("pkt_next", 8'h22, 2, 1'b1);
    in_valid = '0;
    step();

    // ptr is now 3: backpressure with out_valid held.
    in_valid = 4'b1000; in_last = 4'b1000; set_data(3, 8'h33);
    step();
    chk_out("bp_first", 8'h33, 3, 1'b1);
    out_ready = 1'b0; set_data(3, 8'h34);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(in_ready), 32'h0);
      step();
      chk_out("bp_hold", 8'h33, 3, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(in_ready), 32'b1000);
    step();
    in_valid = '0;
    chk_out("bp_next", 8'h34, 3, 1'b1);
    step();
    chk("bp_nodup", 32'(out_valid), 32'h0);

    // ptr is now 0: move it to 2, open a packet on ch2, reset mid-packet.
    in_valid = 4'b0010; in_last = 4'b0010; set_data(1, 8'h41);
    step();
    chk_out("pre_rst", 8'h41, 1, 1'b1);
    in_valid = 4'b0100; in_last = 4'b0000; set_data(2, 8'h51);
    step();
    chk_out("lock2", 8'h51, 2, 1'b0);
    rst = 1'b1; set_data(2, 8'h52);
    #1;
    chk("rst_lock_ready", 32'(in_ready), 32'h0);
    step();
    chk("rst_lock_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    in_valid = 4'b1010; in_last = 4'b1010; set_data(1, 8'h61); set_data(3, 8'h77);
    #1;
    chk("post_rst_ptr0", 32'(in_ready), 32'b0010);
    step();
    chk_out("post_rst_ch1", 8'h61, 1, 1'b1);
    in_valid = 4'b1000; in_last = 4'b1000;
    #1;
    chk("post_rst_ch3_ready", 32'(in_ready), 32'b1000);
    step();
    in_valid = '0;
    chk_out("post_rst_ch3", 8'h77, 3, 1'b1);
    step();
    chk("final_drain", 32'(out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
